lbp_host: RTL and testbench

- Host-side responder for the LBP engine's two memory interfaces: it serves gray-pixel read requests and captures LBP result writes.
- Frames one image job: load the gray image from an upstream stream, serve the engine until it raises finish, then stream the result image out in address order.
- Sits between the system data path and the LBP engine; contains the gray image buffer and the LBP result buffer.

---
 rtl/lbp_host.sv | 190 +++++++++++++++++++
 tb/tb_lbp_host.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_host.sv
// lbp_host
// Host-side responder for the LBP engine. One image job runs in four phases:
//   LOAD    : accept the gray image from the upstream stream (address order)
//             and clear the result buffer at the same addresses.
//   SERVE   : answer engine gray reads (1-cycle latency) and capture engine
//             result writes until the engine raises finish.
//   READOUT : stream the result buffer out in address order with a
//             valid/ready handshake, flagging the final pixel with res_last.
//   DONE    : hold done high until the next start.
//
// Ports
//   clk, reset              : single rising-edge clock, synchronous active-high reset
//   start                   : job start pulse, honoured in IDLE or DONE only
//   img_valid/img_data      : upstream gray pixel stream
//   img_ready               : high only while loading
//   gray_ready              : high only while serving the engine
//   gray_req/gray_addr      : engine read request
//   gray_data               : registered read data
//   lbp_valid/addr/data     : engine result write
//   finish                  : engine completion flag
//   res_valid/ready/data    : result stream to downstream
//   res_last                : marks the beat for the final address
//   done                    : high once the result stream has completed
module lbp_host #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  output logic              img_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic              done
);

  localparam int N_PIX = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SERVE,
    READOUT,
    DONE
  } state_e;

  state_e state_q;

  // loadCnt_q walks the image during LOAD; readCnt_q is the address of the
  // next result pixel to fetch into the output register during READOUT.
  logic [ADDR_W-1:0] loadCnt_q;
  logic [ADDR_W-1:0] readCnt_q;

  logic              imgReady_q;
  logic              grayReady_q;
  logic [DATA_W-1:0] grayData_q;
  logic              resValid_q;
  logic [DATA_W-1:0] resData_q;
  logic              resLast_q;
  logic              done_q;

  // Image and result storage. Contents survive reset on purpose; every job
  // rewrites all of both buffers during LOAD before the engine sees them.
  logic [DATA_W-1:0] grayBuf   [N_PIX];
  logic [DATA_W-1:0] resultBuf [N_PIX];

  logic loadBeat;
  logic serveWrite;
  logic lastXfer;
  logic outRegFree;

  // Handshake strobes shared by the buffer writes and the control FSM.
  // img_ready is exactly "state is LOAD", so the state compare stands in for it.
  // The output register may take a new pixel when it is empty or when the
  // pixel it holds is being accepted this cycle.
  always_comb begin
    loadBeat   = (state_q == LOAD) && img_valid && !reset;
    serveWrite = (state_q == SERVE) && lbp_valid && !reset;
    lastXfer   = resValid_q && res_ready && resLast_q;
    outRegFree = !resValid_q || res_ready;
  end

  // Buffer write ports. During LOAD the result slot is zeroed alongside the
  // gray write so that pixels the engine never writes read back as 0. The
  // two write sources for resultBuf live in different states and never collide.
  always_ff @(posedge clk) begin
    if (loadBeat) begin
      grayBuf[loadCnt_q]   <= img_data;
      resultBuf[loadCnt_q] <= '0;
    end else if (serveWrite) begin
      resultBuf[lbp_addr] <= lbp_data;
    end
  end

  // Job control FSM with all outputs registered.
  // READOUT uses a single output register: the first cycle after entry fills
  // it, after which each accepted beat is replaced by the next pixel in the
  // same cycle, giving one beat per clock under continuous res_ready. When the
  // beat carrying res_last is accepted the stream closes and DONE follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      loadCnt_q   <= '0;
      readCnt_q   <= '0;
      imgReady_q  <= 1'b0;
      grayReady_q <= 1'b0;
      grayData_q  <= '0;
      resValid_q  <= 1'b0;
      resData_q   <= '0;
      resLast_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= LOAD;
            loadCnt_q  <= '0;
            imgReady_q <= 1'b1;
            done_q     <= 1'b0;
          end
        end

        LOAD: begin
          if (img_valid) begin
            loadCnt_q <= loadCnt_q + 1'b1;
            if (loadCnt_q == LAST_ADDR) begin
              state_q     <= SERVE;
              imgReady_q  <= 1'b0;
              grayReady_q <= 1'b1;
            end
          end
        end

        SERVE: begin
          // A read or write arriving together with finish is still served.
          if (gray_req) begin
            grayData_q <= grayBuf[gray_addr];
          end
          if (finish) begin
            state_q     <= READOUT;
            grayReady_q <= 1'b0;
            readCnt_q   <= '0;
            resValid_q  <= 1'b0;
            resLast_q   <= 1'b0;
          end
        end

        READOUT: begin
          if (lastXfer) begin
            state_q    <= DONE;
            resValid_q <= 1'b0;
            resLast_q  <= 1'b0;
            done_q     <= 1'b1;
          end else if (outRegFree) begin
            resData_q  <= resultBuf[readCnt_q];
            resLast_q  <= (readCnt_q == LAST_ADDR);
            resValid_q <= 1'b1;
            readCnt_q  <= readCnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign img_ready  = imgReady_q;
  assign gray_ready = grayReady_q;
  assign gray_data  = grayData_q;
  assign res_valid  = resValid_q;
  assign res_data   = resData_q;
  assign res_last   = resLast_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lbp_host.sv
// tb_lbp_host
// Drives a 16-pixel lbp_host through deterministic, table-driven and random
// jobs, plus a full 16384-pixel job on a second instance. The expected
// behaviour comes from a plain array model of the two image buffers.
module tb_lbp_host;

  localparam int AW  = 4;
  localparam int N   = 1 << AW;
  localparam int BAW = 14;
  localparam int BN  = 1 << BAW;

  logic clk = 1'b0;
  logic reset;

  // Small (16-pixel) instance
  logic          start, imgValid, imgReady, grayReady, grayReq;
  logic [7:0]    imgData, grayData, lbpData, resData;
  logic [AW-1:0] grayAddr, lbpAddr;
  logic          lbpValid, finish, resValid, resReady, resLast, done;

  // Large (16384-pixel) instance
  logic           bStart, bImgValid, bImgReady, bGrayReady, bGrayReq;
  logic [7:0]     bImgData, bGrayData, bLbpData, bResData;
  logic [BAW-1:0] bGrayAddr, bLbpAddr;
  logic           bLbpValid, bFinish, bResValid, bResReady, bResLast, bDone;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: buffer contents and the value gray_data should hold.
  logic [7:0] grayM [N];
  logic [7:0] resM  [N];
  logic [7:0] gdExp;

  typedef struct packed {
    logic          start;
    logic          imgValid;
    logic [7:0]    imgData;
    logic          grayReq;
    logic [AW-1:0] grayAddr;
    logic          lbpValid;
    logic [AW-1:0] lbpAddr;
    logic [7:0]    lbpData;
    logic          finish;
    logic          resReady;
  } inVec_t;

  typedef struct packed {
    logic       imgReady;
    logic       grayReady;
    logic [7:0] grayData;
    logic       resValid;
    logic [7:0] resData;
    logic       resLast;
    logic       done;
  } outVec_t;

  typedef struct {
    string   name;
    inVec_t  in;
    outVec_t exp;
  } vec_t;

  vec_t tbl [8];

  lbp_host #(.ADDR_W(AW), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_valid(imgValid), .img_data(imgData), .img_ready(imgReady),
    .gray_ready(grayReady), .gray_req(grayReq), .gray_addr(grayAddr), .gray_data(grayData),
    .lbp_valid(lbpValid), .lbp_addr(lbpAddr), .lbp_data(lbpData),
    .finish(finish),
    .res_valid(resValid), .res_ready(resReady), .res_data(resData), .res_last(resLast),
    .done(done)
  );

  lbp_host #(.ADDR_W(BAW), .DATA_W(8)) bigDut (
    .clk(clk), .reset(reset), .start(bStart),
    .img_valid(bImgValid), .img_data(bImgData), .img_ready(bImgReady),
    .gray_ready(bGrayReady), .gray_req(bGrayReq), .gray_addr(bGrayAddr), .gray_data(bGrayData),
    .lbp_valid(bLbpValid), .lbp_addr(bLbpAddr), .lbp_data(bLbpData),
    .finish(bFinish),
    .res_valid(bResValid), .res_ready(bResReady), .res_data(bResData), .res_last(bResLast),
    .done(bDone)
  );

  always #5 clk = ~clk;

  // Global time limit so a stuck DUT can never hang the run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input inVec_t v);
    start    = v.start;
    imgValid = v.imgValid;
    imgData  = v.imgData;
    grayReq  = v.grayReq;
    grayAddr = v.grayAddr;
    lbpValid = v.lbpValid;
    lbpAddr  = v.lbpAddr;
    lbpData  = v.lbpData;
    finish   = v.finish;
    resReady = v.resReady;
    stepClock();
  endtask

  function automatic inVec_t mkIn(input logic st, input logic iv, input logic [7:0] id,
                                  input logic gr, input logic [AW-1:0] ga,
                                  input logic lv, input logic [AW-1:0] la, input logic [7:0] ld,
                                  input logic fin, input logic rr);
    inVec_t v;
    v = '{start: st, imgValid: iv, imgData: id, grayReq: gr, grayAddr: ga,
          lbpValid: lv, lbpAddr: la, lbpData: ld, finish: fin, resReady: rr};
    return v;
  endfunction

  function automatic outVec_t mkOut(input logic ir, input logic grdy, input logic [7:0] gd,
                                    input logic rv, input logic [7:0] rd, input logic rl,
                                    input logic dn);
    outVec_t o;
    o = '{imgReady: ir, grayReady: grdy, grayData: gd, resValid: rv,
          resData: rd, resLast: rl, done: dn};
    return o;
  endfunction

  // Start a job and stream all N pixels in. Random mode inserts idle gaps,
  // random data and stray start pulses (which LOAD must ignore).
  task automatic loadImage(input bit randomMode);
    inVec_t v;
    int i;
    int cyc;
    v = '0;
    v.start    = 1'b1;
    v.imgValid = 1'b1;
    v.imgData  = 8'hEE;
    applyStimulus(v);
    checkOutput("loadEntry.imgReady", 32'(imgReady), 32'(1));
    checkOutput("loadEntry.done", 32'(done), 32'(0));
    i = 0;
    cyc = 0;
    while (i < N && cyc < 200) begin
      checkOutput("load.imgReady", 32'(imgReady), 32'(1));
      v = '0;
      v.imgValid = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
      v.imgData  = randomMode ? 8'($urandom) : 8'(8'h10 + i);
      v.start    = randomMode ? ($urandom_range(0, 7) == 0) : 1'b0;
      v.grayReq  = 1'($urandom_range(0, 1));
      v.grayAddr = AW'($urandom);
      v.lbpValid = 1'($urandom_range(0, 1));
      v.lbpAddr  = AW'($urandom);
      v.lbpData  = 8'($urandom);
      applyStimulus(v);
      if (v.imgValid) begin
        grayM[i] = v.imgData;
        resM[i]  = 8'h00;
        i++;
      end
      cyc++;
    end
    if (i < N) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL load.timeout: got %0d beats, expected %0d", i, N);
    end
    checkOutput("loadEnd.imgReady", 32'(imgReady), 32'(0));
    checkOutput("loadEnd.grayReady", 32'(grayReady), 32'(1));
    checkOutput("loadEnd.grayData", 32'(grayData), 32'(gdExp));
  endtask

  // Sweep every gray address, then random engine traffic, then finish.
  task automatic serveRandom(input int nOps);
    inVec_t v;
    for (int a = 0; a < N; a++) begin
      v = '0;
      v.grayReq  = 1'b1;
      v.grayAddr = AW'(a);
      applyStimulus(v);
      gdExp = grayM[a];
      checkOutput("serve.sweep", 32'(grayData), 32'(gdExp));
    end
    for (int n = 0; n <= nOps; n++) begin
      v = '0;
      v.grayReq  = 1'($urandom_range(0, 1));
      v.grayAddr = AW'($urandom);
      v.lbpValid = 1'($urandom_range(0, 1));
      v.lbpAddr  = AW'($urandom);
      v.lbpData  = 8'($urandom);
      v.imgValid = 1'($urandom_range(0, 1));
      v.imgData  = 8'($urandom);
      v.start    = ($urandom_range(0, 7) == 0);
      v.resReady = 1'($urandom_range(0, 1));
      v.finish   = (n == nOps);
      applyStimulus(v);
      if (v.grayReq) gdExp = grayM[v.grayAddr];
      if (v.lbpValid) resM[v.lbpAddr] = v.lbpData;
      checkOutput("serve.grayData", 32'(grayData), 32'(gdExp));
      checkOutput("serve.grayReady", 32'(grayReady), 32'(n != nOps));
      checkOutput("serve.resValid", 32'(resValid), 32'(0));
    end
  endtask

  // Collect the result stream and compare it with the model. Mode 0 repeats
  // res_ready = 1,0,0,1; mode 1 randomises it. Engine and upstream inputs are
  // driven with junk throughout and must not disturb anything.
  task automatic drainReadout(input bit randomMode);
    inVec_t v;
    int idx;
    int cyc;
    int w;
    int p;
    bit xfer;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    w = 0;
    while (!resValid && w < 3) begin
      v = '0;
      applyStimulus(v);
      w++;
    end
    checkOutput("readout.firstValid", 32'(resValid && (w <= 2)), 32'(1));
    idx = 0;
    cyc = 0;
    p = 0;
    while (idx < N && cyc < 400) begin
      if (resValid) begin
        checkOutput("readout.data", 32'(resData), 32'(resM[idx]));
        checkOutput("readout.last", 32'(resLast), 32'(idx == N - 1));
      end
      v = '0;
      v.resReady = randomMode ? 1'($urandom_range(0, 1)) : pat[p % 4];
      v.grayReq  = 1'($urandom_range(0, 1));
      v.grayAddr = AW'($urandom);
      v.lbpValid = 1'($urandom_range(0, 1));
      v.lbpAddr  = AW'($urandom);
      v.lbpData  = 8'($urandom);
      v.imgValid = 1'($urandom_range(0, 1));
      v.imgData  = 8'($urandom);
      v.start    = ($urandom_range(0, 5) == 0);
      xfer = resValid && v.resReady;
      applyStimulus(v);
      p++;
      cyc++;
      checkOutput("readout.grayHeld", 32'(grayData), 32'(gdExp));
      checkOutput("readout.grayReady", 32'(grayReady), 32'(0));
      if (xfer) begin
        idx++;
        if (idx < N) checkOutput("readout.noBubble", 32'(resValid), 32'(1));
      end
    end
    if (idx < N) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL readout.timeout: got %0d beats, expected %0d", idx, N);
    end
    checkOutput("readout.endValid", 32'(resValid), 32'(0));
    checkOutput("done.set", 32'(done), 32'(1));
    v = '0;
    applyStimulus(v);
    checkOutput("done.hold", 32'(done), 32'(1));
    checkOutput("done.imgReady", 32'(imgReady), 32'(0));
  endtask

  function automatic logic [7:0] bigExp(input int a);
    case (a)
      0:       return 8'h3C;
      100:     return 8'h99;
      BN - 1:  return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    inVec_t v;
    int idx;
    int cyc;

    // Second job's SERVE phase: reads, ignored inputs, repeated writes and
    // a read + write + finish in one cycle, then two stalled READOUT cycles.
    tbl[0] = '{"serveIdle",      mkIn(0,0,8'h00,0,4'd0, 0,4'd0,8'h00,0,0), mkOut(0,1,8'h15,0,8'h00,0,0)};
    tbl[1] = '{"readAddr0",      mkIn(0,0,8'h00,1,4'd0, 0,4'd0,8'h00,0,0), mkOut(0,1,8'h10,0,8'h00,0,0)};
    tbl[2] = '{"ignoreStartImg", mkIn(1,1,8'hEE,0,4'd0, 0,4'd0,8'h00,0,0), mkOut(0,1,8'h10,0,8'h00,0,0)};
    tbl[3] = '{"write3First",    mkIn(0,0,8'h00,1,4'd15,1,4'd3,8'h11,0,0), mkOut(0,1,8'h1F,0,8'h00,0,0)};
    tbl[4] = '{"write3Last",     mkIn(0,0,8'h00,0,4'd0, 1,4'd3,8'hAA,0,0), mkOut(0,1,8'h1F,0,8'h00,0,0)};
    tbl[5] = '{"sameCycle",      mkIn(0,0,8'h00,1,4'd7, 1,4'd7,8'h55,1,0), mkOut(0,0,8'h17,0,8'h00,0,0)};
    tbl[6] = '{"lateReq",        mkIn(0,0,8'h00,1,4'd2, 1,4'd8,8'h77,0,0), mkOut(0,0,8'h17,1,8'h00,0,0)};
    tbl[7] = '{"stallStart",     mkIn(1,0,8'h00,0,4'd0, 0,4'd0,8'h00,0,0), mkOut(0,0,8'h17,1,8'h00,0,0)};

    bStart = 0; bImgValid = 0; bImgData = 0; bGrayReq = 0; bGrayAddr = 0;
    bLbpValid = 0; bLbpAddr = 0; bLbpData = 0; bFinish = 0; bResReady = 0;
    for (int i = 0; i < N; i++) begin
      grayM[i] = 8'h00;
      resM[i]  = 8'h00;
    end

    // Reset values
    reset = 1'b1;
    v = '0;
    applyStimulus(v);
    applyStimulus(v);
    reset = 1'b0;
    gdExp = 8'h00;
    checkOutput("reset.imgReady", 32'(imgReady), 32'(0));
    checkOutput("reset.grayReady", 32'(grayReady), 32'(0));
    checkOutput("reset.grayData", 32'(grayData), 32'(0));
    checkOutput("reset.resValid", 32'(resValid), 32'(0));
    checkOutput("reset.resData", 32'(resData), 32'(0));
    checkOutput("reset.resLast", 32'(resLast), 32'(0));
    checkOutput("reset.done", 32'(done), 32'(0));
    checkOutput("reset.bigDone", 32'(bDone), 32'(0));

    // Normal job: pixel i = 0x10+i, engine writes ~i everywhere
    loadImage(1'b0);
    v = '0;
    v.grayReq  = 1'b1;
    v.grayAddr = 4'd5;
    applyStimulus(v);
    gdExp = 8'h15;
    checkOutput("normal.readAddr5", 32'(grayData), 32'(8'h15));
    for (int i = 0; i < N; i++) begin
      v = '0;
      v.lbpValid = 1'b1;
      v.lbpAddr  = AW'(i);
      v.lbpData  = ~8'(i);
      applyStimulus(v);
      resM[i] = ~8'(i);
    end
    v = '0;
    v.finish = 1'b1;
    applyStimulus(v);
    checkOutput("normal.grayReadyDrop", 32'(grayReady), 32'(0));
    drainReadout(1'b0);

    // Table-driven job: sparse writes, last-write-wins, same-cycle events
    loadImage(1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(tbl[k].in);
      checkOutput({tbl[k].name, ".imgReady"}, 32'(imgReady), 32'(tbl[k].exp.imgReady));
      checkOutput({tbl[k].name, ".grayReady"}, 32'(grayReady), 32'(tbl[k].exp.grayReady));
      checkOutput({tbl[k].name, ".grayData"}, 32'(grayData), 32'(tbl[k].exp.grayData));
      checkOutput({tbl[k].name, ".resValid"}, 32'(resValid), 32'(tbl[k].exp.resValid));
      checkOutput({tbl[k].name, ".done"}, 32'(done), 32'(tbl[k].exp.done));
      if (tbl[k].exp.resValid) begin
        checkOutput({tbl[k].name, ".resData"}, 32'(resData), 32'(tbl[k].exp.resData));
        checkOutput({tbl[k].name, ".resLast"}, 32'(resLast), 32'(tbl[k].exp.resLast));
      end
    end
    // Only the writes made in SERVE land: addr 3 (last value) and addr 7.
    resM[3] = 8'hAA;
    resM[7] = 8'h55;
    gdExp   = 8'h17;
    drainReadout(1'b0);

    // Reset in the middle of LOAD, on the tenth beat
    v = '0;
    v.start = 1'b1;
    applyStimulus(v);
    for (int i = 0; i < 9; i++) begin
      v = '0;
      v.imgValid = 1'b1;
      v.imgData  = 8'(8'h80 + i);
      applyStimulus(v);
    end
    v = '0;
    v.imgValid = 1'b1;
    v.imgData  = 8'h99;
    reset = 1'b1;
    applyStimulus(v);
    reset = 1'b0;
    gdExp = 8'h00;
    checkOutput("midReset.imgReady", 32'(imgReady), 32'(0));
    checkOutput("midReset.grayReady", 32'(grayReady), 32'(0));
    checkOutput("midReset.grayData", 32'(grayData), 32'(0));
    checkOutput("midReset.resValid", 32'(resValid), 32'(0));
    checkOutput("midReset.resData", 32'(resData), 32'(0));
    checkOutput("midReset.resLast", 32'(resLast), 32'(0));
    checkOutput("midReset.done", 32'(done), 32'(0));
    v = '0;
    v.imgValid = 1'b1;
    applyStimulus(v);
    checkOutput("midReset.staysIdle", 32'(imgReady), 32'(0));

    // Random jobs; the first one also proves reload from address 0
    for (int r = 0; r < 3; r++) begin
      loadImage(1'b1);
      serveRandom(30);
      drainReadout(1'b1);
    end

    // Full-size job on the 14-bit instance
    bStart = 1'b1;
    stepClock();
    bStart = 1'b0;
    checkOutput("big.loadEntry", 32'(bImgReady), 32'(1));
    for (int i = 0; i < BN; i++) begin
      bImgValid = 1'b1;
      bImgData  = 8'(i) ^ 8'h5A;
      stepClock();
    end
    bImgValid = 1'b0;
    checkOutput("big.loadEnd.imgReady", 32'(bImgReady), 32'(0));
    checkOutput("big.loadEnd.grayReady", 32'(bGrayReady), 32'(1));
    bGrayReq  = 1'b1;
    bGrayAddr = BAW'(BN - 1);
    stepClock();
    bGrayReq = 1'b0;
    checkOutput("big.readLast", 32'(bGrayData), 32'(8'hA5));
    bLbpValid = 1'b1;
    bLbpAddr = BAW'(0);      bLbpData = 8'h3C; stepClock();
    bLbpAddr = BAW'(100);    bLbpData = 8'h99; stepClock();
    bLbpAddr = BAW'(BN - 1); bLbpData = 8'hC3; stepClock();
    bLbpValid = 1'b0;
    bFinish = 1'b1;
    stepClock();
    bFinish   = 1'b0;
    bResReady = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < BN && cyc < BN + 20) begin
      if (bResValid) begin
        checkOutput("big.data", 32'(bResData), 32'(bigExp(idx)));
        checkOutput("big.last", 32'(bResLast), 32'(idx == BN - 1));
        idx++;
      end
      stepClock();
      cyc++;
    end
    if (idx < BN) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL big.timeout: got %0d beats, expected %0d", idx, BN);
    end
    checkOutput("big.endValid", 32'(bResValid), 32'(0));
    checkOutput("big.done", 32'(bDone), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
